dm_ctrl: RTL and testbench
==========================

# dm_ctrl

Parametrised data memory with a valid/ready request port and a registered response port. It replaces the single-cycle combinational-read data memory with a fixed-latency, one-outstanding-request memory. Supported accesses are word, half and byte, signed and unsigned, each with misalignment and range checking. After reset the array is cleared by a hardware zeroing sweep, so the memory array itself needs no reset. It sits between the MEM stage and the backing store; a request that is not ready stalls the pipeline.

## Interface
- `ADDR_WIDTH`, default 12: word-address bits. Depth = 2^ADDR_WIDTH words, byte range 0 .. 2^(ADDR_WIDTH+2)-1.
- `LATENCY`, default 2: BUSY cycles between acceptance and response. Legal values are ≥1.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low; asserted when 0.
- `req_valid` input 1: request present.
- `req_ready` output 1: request can be accepted this cycle.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_op` input 4: operation. Bit [0] = write. Bits [3:1] = size: 0 WORD, 1 BYTE, 2 HALF, 3 BYTEU, 4 HALFU, 5-7 illegal.
- `resp_valid` output 1: one-cycle pulse per accepted request.
- `resp_rdata` output 32: load result, extended to 32 bits. It is 0 for stores and for errors.
- `resp_err` output 1: request rejected. Valid only with `resp_valid`.
- `clearing` output 1: zeroing sweep in progress.

## Operation
The FSM has three states: CLEAR, IDLE and BUSY.
- **Reset** (`reset`=0, async):
  - state←CLEAR, clr_idx←0.
  - `resp_valid`, `resp_err`, `resp_rdata`←0; `req_ready`=0; `clearing`=1.
  - Any in-flight request is discarded: no write, no response.
- **CLEAR**:
  - Each cycle writes 0 to word clr_idx, then clr_idx+1.
  - After the write of word DEPTH-1, go to IDLE. The sweep takes exactly DEPTH cycles.
  - `req_ready`=0 throughout.
- **IDLE**:
  - `req_ready`=1.
  - On `req_valid`&`req_ready` at an edge: latch addr/wdata/op, cnt←LATENCY-1, go to BUSY.
- **BUSY**:
  - `req_ready`=0. Input changes are ignored.
  - cnt decrements each cycle. On the edge that leaves BUSY (cnt=0): perform the access, register the response, set `resp_valid`=1, go to IDLE.
- **Error check**, evaluated on the latched request:
  - err = illegal size, OR addr[31:ADDR_WIDTH+2]≠0, OR (HALF/HALFU and addr[0]), OR (WORD and addr[1:0]≠0).
  - An erroring access never writes; `resp_rdata`=0, `resp_err`=1.
- **Store**, byte lanes chosen by addr[1:0]:
  - BYTE writes wdata[7:0] into lane addr[1:0].
  - HALF writes wdata[15:0] into lanes {addr[1],0}+1 : {addr[1],0}.
  - WORD writes the full word.
  - Other lanes are untouched.
  - Store with BYTEU/HALFU size is an error.
- **Load**:
  - Select the lane(s) as for stores.
  - BYTE/HALF sign-extend; BYTEU/HALFU zero-extend.
- **`resp_valid`** falls the cycle after its pulse unless a new response completes. `resp_rdata` and `resp_err` hold until the next response.

## Timing
- Request accepted at the edge ending cycle t:
  - BUSY during cycles t+1 .. t+LATENCY.
  - Write commits / read data is sampled at the edge ending t+LATENCY.
  - `resp_valid`=1 and `req_ready`=1 during cycle t+LATENCY+1.
- A new request may be accepted in the response cycle. Peak throughput is one request per LATENCY+1 cycles.
- Load after store to the same word: the load sees the stored data (one outstanding request, write committed before the response).
- `reset` going to 0 in any state takes effect immediately (async). Its deassertion is released at the next edge into CLEAR with clr_idx=0.
- `req_valid` held high during CLEAR or BUSY is not accepted and is not queued.

## Test plan
- **Clear sweep**, ADDR_WIDTH=4, LATENCY=2, memory pre-filled with X:
  - release reset → `clearing`=1 for exactly 16 cycles, then `req_ready`=1.
  - lw @0x3C → `resp_rdata`=0x00000000, `resp_err`=0.
- **Word/byte**:
  - sw 0x12345678 @0x8.
  - lb @0x9 → 0x00000056.
  - lb @0xB → 0x00000012.
  - sb 0x80 @0x8, then lb @0x8 → 0xFFFFFF80 and lbu @0x8 → 0x00000080.
- **Half**, continuing from the word/byte scenario:
  - sh 0xBEEF @0xA, then lw @0x8 → 0xBEEF5680.
  - lh @0xA → 0xFFFFBEEF.
  - lhu @0xA → 0x0000BEEF.
- **Errors**:
  - lw @0x6 → `resp_err`=1, `resp_rdata`=0.
  - sh @0x9 → `resp_err`=1, word 0x8 unchanged.
  - op size 5 → `resp_err`=1.
  - lw @0x40 (ADDR_WIDTH=4) → `resp_err`=1.
- **Latency/handshake**, LATENCY=3, `req_valid` held high:
  - accept in cycle t → `req_ready`=0 in t+1..t+3.
  - `resp_valid` in t+4 for exactly one cycle.
  - second request accepted in t+4, its response in t+8.
- **Reset mid-operation**:
  - sw 0xDEADBEEF @0x4, then assert `reset` during BUSY → no `resp_valid` pulse.
  - after the clear sweep, lw @0x4 → 0x00000000.

Source files
------------

// File: rtl/dm_ctrl.sv
// dm_ctrl: fixed-latency data memory with valid/ready request port,
// registered response, byte/half/word access and post-reset zeroing sweep.
module dm_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_op,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        clearing
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [2:0] SZ_WORD  = 3'd0;
    localparam logic [2:0] SZ_BYTE  = 3'd1;
    localparam logic [2:0] SZ_HALF  = 3'd2;
    localparam logic [2:0] SZ_BYTEU = 3'd3;
    localparam logic [2:0] SZ_HALFU = 3'd4;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic [CW-1:0]         cnt;
    logic [31:0]           l_addr;
    logic [31:0]           l_wdata;
    logic [3:0]            l_op;

    logic [31:0] mem [DEPTH];

    logic                  accept, done, err;
    logic [2:0]            size;
    logic                  is_wr;
    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0]           rword, bsel, hsel, ldata;
    logic [31:0]           wmask, wdat;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic [31:0]           mem_wd;

    assign size     = l_op[3:1];
    assign is_wr    = l_op[0];
    assign off      = l_addr[1:0];
    assign widx     = l_addr[ADDR_WIDTH+1:2];
    assign rword    = mem[widx];
    assign bsel     = rword >> {off, 3'b000};
    assign hsel     = rword >> {off[1], 4'b0000};
    assign accept   = (state == ST_IDLE) && req_valid;
    assign done     = (state == ST_BUSY) && (cnt == '0);
    assign req_ready = (state == ST_IDLE);
    assign clearing  = (state == ST_CLEAR);

    always_comb begin
        err = 1'b0;
        if (size > SZ_HALFU) err = 1'b1;
        if (l_addr[31:ADDR_WIDTH+2] != '0) err = 1'b1;
        if ((size == SZ_HALF || size == SZ_HALFU) && off[0]) err = 1'b1;
        if (size == SZ_WORD && off != 2'b00) err = 1'b1;
        // Unsigned sizes only make sense for loads
        if (is_wr && (size == SZ_BYTEU || size == SZ_HALFU)) err = 1'b1;
    end

    always_comb begin
        ldata = 32'h0;
        wmask = 32'h0;
        wdat  = 32'h0;
        unique case (size)
            SZ_WORD: begin
                ldata = rword;
                wmask = 32'hFFFF_FFFF;
                wdat  = l_wdata;
            end
            SZ_BYTE, SZ_BYTEU: begin
                ldata = (size == SZ_BYTE) ? {{24{bsel[7]}}, bsel[7:0]}
                                          : {24'h0, bsel[7:0]};
                wmask = 32'h0000_00FF << {off, 3'b000};
                wdat  = {4{l_wdata[7:0]}};
            end
            SZ_HALF, SZ_HALFU: begin
                ldata = (size == SZ_HALF) ? {{16{hsel[15]}}, hsel[15:0]}
                                          : {16'h0, hsel[15:0]};
                wmask = 32'h0000_FFFF << {off[1], 4'b0000};
                wdat  = {2{l_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_we  = 1'b0;
        mem_idx = widx;
        mem_wd  = (rword & ~wmask) | (wdat & wmask);
        if (state == ST_CLEAR) begin
            mem_we  = 1'b1;
            mem_idx = clr_idx;
            mem_wd  = 32'h0;
        end else if (done && is_wr && !err) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wd;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_CLEAR: if (clr_idx == ADDR_WIDTH'(DEPTH - 1)) state_nx = ST_IDLE;
            ST_IDLE:  if (accept) state_nx = ST_BUSY;
            ST_BUSY:  if (cnt == '0) state_nx = ST_IDLE;
            default:  state_nx = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_CLEAR;
            clr_idx    <= '0;
            cnt        <= '0;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_op       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            resp_valid <= done;
            if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
            if (accept) begin
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
                l_op    <= req_op;
                cnt     <= CW'(LATENCY - 1);
            end else if (state == ST_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (done) begin
                resp_err   <= err;
                resp_rdata <= (err || is_wr) ? 32'h0 : ldata;
            end
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed checks of dm_ctrl with ADDR_WIDTH=4,
// LATENCY=2 (main instance) and LATENCY=3 (handshake instance).
module tb_dm_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_op;
    logic        resp_valid, resp_err, clearing;
    logic [31:0] resp_rdata;

    logic        v3, r3, rv3, re3, cl3;
    logic [31:0] a3, wd3, rd3;
    logic [3:0]  op3;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] LW  = 4'h0, SW = 4'h1, LB = 4'h2, SB = 4'h3;
    localparam logic [3:0] LH  = 4'h4, SH = 4'h5, LBU = 4'h6, LHU = 4'h8;
    localparam logic [3:0] BAD = 4'hA;

    dm_ctrl #(.ADDR_WIDTH(4), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_op(req_op),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .clearing(clearing)
    );

    dm_ctrl #(.ADDR_WIDTH(4), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(v3), .req_ready(r3),
        .req_addr(a3), .req_wdata(wd3), .req_op(op3),
        .resp_valid(rv3), .resp_rdata(rd3),
        .resp_err(re3), .clearing(cl3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic txn(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic e, output bit to);
        int n;
        to = 1'b0;
        n  = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) to = 1'b1;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) to = 1'b1;
        rd = resp_rdata;
        e  = resp_err;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || clearing !== 1'b1 || resp_valid !== 1'b0 ||
            resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state rdy=%b clr=%b rv=%b err=%b rd=%h req 0 1 0 0 0",
                     req_ready, clearing, resp_valid, resp_err, resp_rdata);
        end
    endtask

    task automatic test_clear;
        int n;
        logic [31:0] rd;
        logic e;
        bit to;
        @(posedge clk);
        #1 reset = 1'b1;
        n = 0;
        @(negedge clk);
        while (clearing && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_len got %0d cycles rdy=%b req 16 rdy=1", n, req_ready);
        end
        txn(LW, 32'h3C, 32'h0, rd, e, to);
        checks++;
        if (to || rd !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL clear_lw3c got %h err=%b to=%b req 00000000 0", rd, e, to);
        end
    endtask

    task automatic test_word_byte;
        logic [31:0] rd;
        logic e;
        bit to;
        txn(SW, 32'h8, 32'h1234_5678, rd, e, to);
        checks++;
        if (to || rd !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL sw_resp got %h err=%b req 00000000 0", rd, e);
        end
        txn(LB, 32'h9, 32'h0, rd, e, to);
        checks++;
        if (to || rd !== 32'h0000_0056 || e) begin
            errors++;
            $display("FAIL lb9 got %h req 00000056", rd);
        end
        txn(LB, 32'hB, 32'h0, rd, e, to);
        checks++;
        if (to || rd !== 32'h0000_0012 || e) begin
            errors++;
            $display("FAIL lbB got %h req 00000012", rd);
        end
        txn(SB, 32'h8, 32'h0000_0080, rd, e, to);
        txn(LB, 32'h8, 32'h0, rd, e, to);
        checks++;
        if (to || rd !== 32'hFFFF_FF80 || e) begin
            errors++;
            $display("FAIL lb8 got %h req ffffff80", rd);
        end
        txn(LBU, 32'h8, 32'h0, rd, e, to);
        checks++;
        if (to || rd !== 32'h0000_0080 || e) begin
            errors++;
            $display("FAIL lbu8 got %h req 00000080", rd);
        end
    endtask

    task automatic test_half;
        logic [31:0] rd;
        logic e;
        bit to;
        txn(SH, 32'hA, 32'h0000_BEEF, rd, e, to);
        txn(LW, 32'h8, 32'h0, rd, e, to);
        checks++;
        if (to || rd !== 32'hBEEF_5680 || e) begin
            errors++;
            $display("FAIL lw8_after_sh got %h req beef5680", rd);
        end
        txn(LH, 32'hA, 32'h0, rd, e, to);
        checks++;
        if (to || rd !== 32'hFFFF_BEEF || e) begin
            errors++;
            $display("FAIL lhA got %h req ffffbeef", rd);
        end
        txn(LHU, 32'hA, 32'h0, rd, e, to);
        checks++;
        if (to || rd !== 32'h0000_BEEF || e) begin
            errors++;
            $display("FAIL lhuA got %h req 0000beef", rd);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic e;
        bit to;
        txn(LW, 32'h6, 32'h0, rd, e, to);
        checks++;
        if (to || e !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL lw6_misalign got err=%b rd=%h req 1 00000000", e, rd);
        end
        txn(SH, 32'h9, 32'h0000_1111, rd, e, to);
        checks++;
        if (to || e !== 1'b1) begin
            errors++;
            $display("FAIL sh9_misalign got err=%b req 1", e);
        end
        txn(LW, 32'h8, 32'h0, rd, e, to);
        checks++;
        if (to || rd !== 32'hBEEF_5680 || e) begin
            errors++;
            $display("FAIL word8_unchanged got %h req beef5680", rd);
        end
        txn(BAD, 32'h0, 32'h0, rd, e, to);
        checks++;
        if (to || e !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL size5 got err=%b rd=%h req 1 00000000", e, rd);
        end
        txn(LW, 32'h40, 32'h0, rd, e, to);
        checks++;
        if (to || e !== 1'b1) begin
            errors++;
            $display("FAIL lw40_range got err=%b req 1", e);
        end
        txn(8'h07 >> 0 == 0 ? LBU : 4'h7, 32'h8, 32'h0, rd, e, to);
        checks++;
        if (to || e !== 1'b1) begin
            errors++;
            $display("FAIL store_byteu got err=%b req 1", e);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bit ok;
        n = 0;
        @(negedge clk);
        v3  = 1'b1;
        op3 = SW;
        a3  = 32'h10;
        wd3 = 32'hCAFE_F00D;
        while (!r3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!r3) begin
            errors++;
            $display("FAIL hs_ready_timeout got rdy=0 req 1");
        end
        // cycle t: accepted at the next edge
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                op3 = LW;
                wd3 = 32'h0;
            end
            ok = 1'b1;
            if (c == 4 || c == 8) begin
                if (rv3 !== 1'b1 || r3 !== 1'b1) ok = 1'b0;
            end else begin
                if (rv3 !== 1'b0 || r3 !== 1'b0) ok = 1'b0;
            end
            if (c == 8) begin
                v3 = 1'b0;
                if (rd3 !== 32'hCAFE_F00D || re3 !== 1'b0) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL hs_t%0d got rv=%b rdy=%b rd=%h", c, rv3, r3, rd3);
            end
        end
        @(negedge clk);
        checks++;
        if (rv3 !== 1'b0 || r3 !== 1'b1) begin
            errors++;
            $display("FAIL hs_t9 got rv=%b rdy=%b req 0 1", rv3, r3);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        logic [31:0] rd;
        logic e;
        bit to;
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 32'h4;
        req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checks++;
        if (seen != 0 || clearing !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid pulses=%0d clr=%b rdy=%b req 0 1 0",
                     seen, clearing, req_ready);
        end
        reset = 1'b1;
        txn(LW, 32'h4, 32'h0, rd, e, to);
        checks++;
        if (to || rd !== 32'h0 || e) begin
            errors++;
            $display("FAIL lw4_after_reset got %h req 00000000", rd);
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_op    = '0;
        v3  = 1'b0;
        a3  = '0;
        wd3 = '0;
        op3 = '0;
        test_reset();
        test_clear();
        test_word_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
